// File: rtl/dma_rd_dispatch.sv
// dma_rd_dispatch: read-side command dispatcher.
// Diced read commands from the DMA controller are buffered in a small FIFO.
// Each command is issued as one AXI4 INCR read burst, and its R beats are
// passed straight through to a local stream output. Only one burst is in
// flight at a time. Burst termination counts beats and never looks at rlast.
// Optional build macro DMA_RD_DISPATCH_ERR_EN: builds a sticky rd_err flag for
// non-OKAY responses or a misplaced rlast. When the macro is undefined,
// rd_err is tied low.
module dma_rd_dispatch #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int CONFIG_LEN_WIDTH = 9,
  parameter int CMD_DEPTH        = 4,
  parameter int RATE             = AXI_DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // command interface from the controller
  input  logic                        config_valid,
  output logic                        config_ready,
  output logic                        config_empty,
  input  logic [CONFIG_LEN_WIDTH-1:0] config_len,
  input  logic [AXI_ADDR_WIDTH-1:0]   config_addr,
  // AXI4 AR channel
  output logic [AXI_ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  // AXI4 R channel
  input  logic [AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  // local read-data stream
  output logic [AXI_DATA_WIDTH-1:0]   out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        rd_err
);

  localparam int PTR_W = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {WAIT_CMD, SEND_AR, RECV_DATA} state_t;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0]   addr;
    logic [CONFIG_LEN_WIDTH-1:0] len;
  } cmd_t;

  cmd_t                        r_mem [CMD_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [PTR_W:0]              r_count;
  state_t                      r_state;
  logic [AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic [7:0]                  r_arlen;
  logic                        r_arvalid;
  logic [CONFIG_LEN_WIDTH-1:0] r_len;
  logic [CONFIG_LEN_WIDTH-1:0] r_beat;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_in_recv;
  logic w_beat_acc;
  logic w_last_beat;
  cmd_t w_head;

  assign w_full      = (r_count == (PTR_W+1)'(CMD_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = config_valid && !w_full;
  assign w_pop       = (r_state == WAIT_CMD) && !w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_in_recv   = (r_state == RECV_DATA);
  assign w_beat_acc  = w_in_recv && rvalid && out_ready;
  assign w_last_beat = (r_beat == r_len - 1'b1);

  assign config_ready = !w_full;
  assign config_empty = w_empty && (r_state == WAIT_CMD);

  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arvalid = r_arvalid;
  assign arsize  = 3'($clog2(RATE));
  assign arburst = 2'b01;

  // R channel is a straight pass-through while a burst is being received.
  assign rready    = w_in_recv && out_ready;
  assign out_valid = w_in_recv && rvalid;
  assign out_data  = w_in_recv ? rdata : '0;

  // Command storage: write the incoming command at the tail.
  // NOTE: storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: config_addr, len: config_len};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Dispatch FSM: pop a command, issue its AR, then count R beats to the end of the burst.
  // NOTE: every register here is next-state logic, so only non-blocking assignments are used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WAIT_CMD;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arvalid <= 1'b0;
      r_len     <= '0;
      r_beat    <= '0;
    end else begin
      case (r_state)
        WAIT_CMD: begin
          if (!w_empty) begin
            r_araddr <= w_head.addr;
            r_arlen  <= 8'(w_head.len - 1'b1);
            r_len    <= w_head.len;
            // A zero-length command is consumed here without issuing an AR.
            if (w_head.len != '0) begin
              r_state   <= SEND_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        SEND_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_beat    <= '0;
            r_state   <= RECV_DATA;
          end
        end
        RECV_DATA: begin
          if (w_beat_acc) begin
            if (w_last_beat) r_state <= WAIT_CMD;
            else             r_beat  <= r_beat + 1'b1;
          end
        end
        default: r_state <= WAIT_CMD;
      endcase
    end
  end

`ifdef DMA_RD_DISPATCH_ERR_EN
  logic r_rd_err;

  // Sticky error: a non-OKAY response, or rlast disagreeing with the beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_err <= 1'b0;
    end else if (w_beat_acc && ((rresp != 2'b00) || (rlast != w_last_beat))) begin
      r_rd_err <= 1'b1;
    end
  end

  assign rd_err = r_rd_err;
`else
  logic w_unused_err_inputs;

  assign w_unused_err_inputs = ^{rresp, rlast};
  assign rd_err              = 1'b0;
`endif

endmodule

// File: tb/tb_dma_rd_dispatch.sv
// Testbench for dma_rd_dispatch.
// Stimulus pushes commands and records the expected AR requests and data beats
// in queues. A behavioural AXI slave answers the ARs. A monitor pops the
// expectations whenever the DUT completes an AR or output handshake.
module tb_dma_rd_dispatch;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LW    = 9;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          config_valid = 1'b0;
  logic          config_ready;
  logic          config_empty;
  logic [LW-1:0] config_len = '0;
  logic [AW-1:0] config_addr = '0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          rd_err;

  always #5 clk = ~clk;

  dma_rd_dispatch #(
    .AXI_ADDR_WIDTH  (AW),
    .AXI_DATA_WIDTH  (DW),
    .CONFIG_LEN_WIDTH(LW),
    .CMD_DEPTH       (DEPTH),
    .RATE            (DW / 8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .config_valid(config_valid),
    .config_ready(config_ready),
    .config_empty(config_empty),
    .config_len  (config_len),
    .config_addr (config_addr),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rd_err      (rd_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    arlen;
  } ar_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
  } burst_t;

  ar_t           ar_q[$];
  logic [DW-1:0] d_q[$];
  burst_t        sq[$];
  ar_t           e_ar;

  int n_pass  = 0;
  int n_total = 0;
  int n_out   = 0;
  int ar_mode = 0;  // 0: arready high, 1: arready low, 2: random
  int or_mode = 0;  // 0: out_ready high, 2: toggle, 3: random
  bit rnd     = 1'b0;
  bit inj     = 1'b0;
  int s_beat  = 0;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
    return (a + AW'(i * 4)) ^ 32'hC3C3_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic fail_now(input string name, input string msg);
    n_total++;
    $display("FAIL %s: %s at %0t", name, msg, $time);
  endtask

  // Reference model: a command of len beats yields one AR (unless len is 0)
  // and len data beats whose values follow from the address.
  task automatic model_push(input logic [AW-1:0] a, input int l);
    if (l != 0) begin
      ar_q.push_back('{addr: a, arlen: 8'(l - 1)});
      for (int i = 0; i < l; i++) d_q.push_back(beat_data(a, i));
    end
  endtask

  // Present a command and hold it until accepted; call between posedge and negedge.
  task automatic push(input logic [AW-1:0] a, input int l);
    int t;
    t            = 0;
    config_valid = 1'b1;
    config_addr  = a;
    config_len   = LW'(l);
    @(negedge clk);
    while (!config_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!config_ready) fail_now("push", "config_ready never asserted");
    else model_push(a, l);
    @(posedge clk);
    #1;
    config_valid = 1'b0;
  endtask

  // Wait until all expected traffic is consumed, then config_empty must already be high.
  task automatic drain(input string name);
    int t;
    int empty_bad;
    t         = 0;
    empty_bad = 0;
    while ((ar_q.size() != 0 || d_q.size() != 0 || sq.size() != 0) && t < 20000) begin
      if (config_empty) empty_bad++;
      @(posedge clk);
      #2;
      t++;
    end
    if (t >= 20000) begin
      fail_now(name, "traffic did not drain");
    end else begin
      check({name, "_empty_after"}, config_empty, 1);
      check({name, "_empty_while_busy"}, empty_bad, 0);
    end
  endtask

  // Behavioural AXI read slave plus downstream ready generator.
  initial begin
    bit ar_fire;
    bit r_fire;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        sq.delete();
        s_beat  = 0;
        rvalid  = 1'b0;
        arready = 1'b0;
      end else begin
        if (ar_fire) sq.push_back('{addr: araddr, len: int'(arlen) + 1});
        if (r_fire && sq.size() != 0) begin
          s_beat++;
          if (s_beat == sq[0].len) begin
            void'(sq.pop_front());
            s_beat = 0;
          end
        end
        case (ar_mode)
          0:       arready = 1'b1;
          1:       arready = 1'b0;
          default: arready = 1'($urandom_range(0, 1));
        endcase
        if (sq.size() != 0) begin
          if (!rvalid || r_fire) rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          rdata = beat_data(sq[0].addr, s_beat);
          rresp = 2'b00;
          rlast = (s_beat == sq[0].len - 1) ^ (inj && s_beat == 1);
        end else begin
          rvalid = 1'b0;
          rlast  = 1'b0;
        end
      end
      case (or_mode)
        0:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every completed AR and output beat against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          fail_now("ar_unexpected", "AR issued with none expected");
        end else begin
          e_ar = ar_q.pop_front();
          check("araddr", araddr, e_ar.addr);
          check("arlen", arlen, e_ar.arlen);
          check("arsize", arsize, 3'd2);
          check("arburst", arburst, 2'd1);
        end
      end
      if (out_valid) check("rready_mirror", rready, out_ready);
      if (out_valid && out_ready) begin
        n_out++;
        if (d_q.size() == 0) fail_now("out_unexpected", "beat forwarded with none expected");
        else check("out_data", out_data, d_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    bit held;
    logic [AW-1:0] a;
    int l;

    // Reset state
    #12;
    check("rst_config_ready", config_ready, 1);
    check("rst_config_empty", config_empty, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_err", rd_err, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 64-beat command with everything ready
    push(32'h1000, 64);
    #1;
    check("ar_latency", arvalid, 0);
    check("empty_after_push", config_empty, 0);
    drain("single");

    // Back-to-back commands with AR stalled: four in the FIFO plus one in SEND_AR
    ar_mode = 1;
    for (int k = 0; k < 5; k++) push(32'h100 * (k + 1), k + 1);
    #1;
    check("full_ready_low", config_ready, 0);
    config_valid = 1'b1;
    config_addr  = 32'h600;
    config_len   = LW'(6);
    held         = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (config_ready) held = 1'b0;
    end
    check("cmd6_held", held, 1);
    check("ar_stalled", ar_q.size(), 5);
    @(posedge clk);
    #1;
    ar_mode = 0;
    push(32'h600, 6);
    drain("six_cmds");

    // len=3 with out_ready toggling
    or_mode = 2;
    push(32'h500, 3);
    drain("toggle");
    or_mode = 0;

    // Zero-length command then a single beat
    push(32'h80, 0);
    push(32'h40, 1);
    drain("len0_len1");

    // Randomised traffic, including a maximum-length burst
    rnd     = 1'b1;
    ar_mode = 2;
    or_mode = 3;
    for (int k = 0; k < 25; k++) begin
      a = $urandom & 32'hFFFF_FFFC;
      l = (k == 10) ? 256 : int'($urandom_range(0, 12));
      if (k == 24) l = 5;
      push(a, l);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain("random");
    rnd     = 1'b0;
    ar_mode = 0;
    or_mode = 0;
    check("rd_err_clean", rd_err, 0);

    // Reset in the middle of a burst
    base = n_out;
    push(32'h2000, 64);
    t = 0;
    while (n_out < base + 10 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail_now("midrst_wait", "burst never started");
    #3 rst_n = 1'b0;
    #1;
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rready", rready, 0);
    check("midrst_config_empty", config_empty, 1);
    check("midrst_config_ready", config_ready, 1);
    ar_q.delete();
    d_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'h3000, 8);
    drain("after_reset");

    // Misplaced rlast on the second beat of a 4-beat burst
    inj = 1'b1;
    push(32'h300, 4);
    drain("bad_rlast");
    inj = 1'b0;
`ifdef DMA_RD_DISPATCH_ERR_EN
    check("rd_err_set", rd_err, 1);
`else
    check("rd_err_tied", rd_err, 0);
`endif
    push(32'h400, 2);
    drain("post_err");
`ifdef DMA_RD_DISPATCH_ERR_EN
    check("rd_err_sticky", rd_err, 1);
`else
    check("rd_err_tied_end", rd_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
